kmap_lut_sweep: RTL and testbench

Parametrised, programmable N-input Boolean function block: a 2^N-entry truth table is loaded serially, evaluated against a live input vector with a registered output, and can autonomously sweep all 2^N input combinations while counting minterms. It generalises fixed 3-input K-map exercise functions into one reusable unit. It sits between the configuration/stimulus logic and the result-check logic of the combinational-logic lab designs, and provides an on-chip exhaustive check.

---
 rtl/kmap_pkg.sv | 12 +
 rtl/kmap_tt_shift.sv | 22 ++
 rtl/kmap_lut_sweep.sv | 97 +++++++++
 tb/tb_kmap_lut_sweep.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/kmap_pkg.sv
// Shared types and limits for the programmable N-input truth-table block.
package kmap_pkg;

  localparam int N_IN_MAX = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } kmap_state_t;

endpackage

// File: rtl/kmap_tt_shift.sv
// Serially loaded truth-table register: new bit enters at the LSB, so the first
// bit shifted in ends up as entry TT_W-1 once TT_W bits have been accepted.
module kmap_tt_shift #(
  parameter int TT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic            i_bit,
  output logic [TT_W-1:0] o_tt
);

  logic [TT_W-1:0] r_tt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_tt <= '0;
    else if (i_en) r_tt <= {r_tt[TT_W-2:0], i_bit};
  end

  assign o_tt = r_tt;

endmodule

// File: rtl/kmap_lut_sweep.sv
// Programmable N-input Boolean function: serial truth-table load, registered
// live evaluation, and an exhaustive sweep that counts minterms.
import kmap_pkg::*;

module kmap_lut_sweep #(
  parameter int N_IN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  input  logic [N_IN-1:0] in_vec,
  output logic            out,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [N_IN-1:0] sweep_idx,
  output logic            sweep_out,
  output logic [N_IN:0]   ones_cnt
);

  localparam int              TT_W     = 2 ** N_IN;
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TT_W - 1);

  kmap_state_t     r_state, w_state_nx;
  logic [N_IN-1:0] r_idx;
  logic [N_IN:0]   r_ones;
  logic            r_out;
  logic [TT_W-1:0] w_tt;
  logic            w_shift;
  logic            w_tt_at_idx;
  logic            w_is_idle, w_is_sweep, w_is_done;
  logic            w_start_ok;

  assign w_is_idle  = (r_state == IDLE);
  assign w_is_sweep = (r_state == SWEEP);
  assign w_is_done  = (r_state == DONE);
  assign w_start_ok = w_is_idle && start;

  // start wins over a same-cycle config bit by withdrawing ready.
  assign cfg_ready = w_is_idle && !start;
  assign w_shift   = cfg_valid && cfg_ready;

  kmap_tt_shift #(.TT_W(TT_W)) u_tt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_shift),
    .i_bit (cfg_bit),
    .o_tt  (w_tt)
  );

  assign w_tt_at_idx = w_tt[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nx = SWEEP;
      SWEEP:   if (r_idx == IDX_LAST) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // idx parks on the last entry after a sweep; it is only cleared by start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_ones <= '0;
    end else if (w_start_ok) begin
      r_idx  <= '0;
      r_ones <= '0;
    end else if (w_is_sweep) begin
      r_ones <= r_ones + {{N_IN{1'b0}}, w_tt_at_idx};
      if (r_idx != IDX_LAST) r_idx <= r_idx + 1'b1;
    end
  end

  // Reads the table as it stands before any shift on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_out <= 1'b0;
    else     r_out <= w_tt[in_vec];
  end

  assign out       = r_out;
  assign busy      = w_is_sweep || w_is_done;
  assign done      = w_is_done;
  assign sweep_idx = r_idx;
  assign sweep_out = w_is_sweep && w_tt_at_idx;
  assign ones_cnt  = r_ones;

endmodule

// File: tb/tb_kmap_lut_sweep.sv
// Directed checks of load, eval, sweep, ignore rules and mid-sweep reset on
// N_IN=3, 1 and 6 instances.
module tb_kmap_lut_sweep;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  // N_IN=3
  logic       cfg_valid3 = 0, cfg_bit3 = 0, start3 = 0;
  logic [2:0] in_vec3 = '0;
  logic       cfg_ready3, out3, busy3, done3, sweep_out3;
  logic [2:0] sweep_idx3;
  logic [3:0] ones3;
  // N_IN=1
  logic       cfg_valid1 = 0, cfg_bit1 = 0, start1 = 0;
  logic [0:0] in_vec1 = '0;
  logic       cfg_ready1, out1, busy1, done1, sweep_out1;
  logic [0:0] sweep_idx1;
  logic [1:0] ones1;
  // N_IN=6
  logic       cfg_valid6 = 0, cfg_bit6 = 0, start6 = 0;
  logic [5:0] in_vec6 = '0;
  logic       cfg_ready6, out6, busy6, done6, sweep_out6;
  logic [5:0] sweep_idx6;
  logic [6:0] ones6;

  kmap_lut_sweep #(.N_IN(3)) dut3 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid3), .cfg_bit(cfg_bit3),
    .cfg_ready(cfg_ready3), .in_vec(in_vec3), .out(out3), .start(start3),
    .busy(busy3), .done(done3), .sweep_idx(sweep_idx3), .sweep_out(sweep_out3),
    .ones_cnt(ones3));

  kmap_lut_sweep #(.N_IN(1)) dut1 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid1), .cfg_bit(cfg_bit1),
    .cfg_ready(cfg_ready1), .in_vec(in_vec1), .out(out1), .start(start1),
    .busy(busy1), .done(done1), .sweep_idx(sweep_idx1), .sweep_out(sweep_out1),
    .ones_cnt(ones1));

  kmap_lut_sweep #(.N_IN(6)) dut6 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid6), .cfg_bit(cfg_bit6),
    .cfg_ready(cfg_ready6), .in_vec(in_vec6), .out(out6), .start(start6),
    .busy(busy6), .done(done6), .sweep_idx(sweep_idx6), .sweep_out(sweep_out6),
    .ones_cnt(ones6));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Full-visibility sweep of dut3 holding the majority table (8'hE8).
  task automatic sweep3(input bit inj_mid, input bit cfg_with_start);
    logic [7:0] pat;
    pat = 8'hE8;
    @(negedge clk);
    start3 = 1;
    if (cfg_with_start) begin
      cfg_valid3 = 1; cfg_bit3 = 1;
      #1 chk("rdy_vs_start", cfg_ready3, 0);
    end
    @(negedge clk);
    start3 = 0; cfg_valid3 = 0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("idx%0d", k), sweep_idx3, k);
      chk($sformatf("sout%0d", k), sweep_out3, pat[k]);
      chk($sformatf("busy%0d", k), busy3, 1);
      chk($sformatf("done_early%0d", k), done3, 0);
      if (inj_mid && k == 2) begin
        start3 = 1; cfg_valid3 = 1; cfg_bit3 = 1;
        #1 chk("rdy_in_sweep", cfg_ready3, 0);
      end else begin
        start3 = 0; cfg_valid3 = 0;
      end
      @(negedge clk);
    end
    start3 = 0; cfg_valid3 = 0;
    chk("done_pulse", done3, 1);
    chk("busy_done", busy3, 1);
    chk("ones_final", ones3, 4);
    @(negedge clk);
    chk("done_clr", done3, 0);
    chk("busy_clr", busy3, 0);
    chk("rdy_back", cfg_ready3, 1);
    chk("ones_hold", ones3, 4);
    @(negedge clk);
    chk("no_2nd_done", done3, 0);
  endtask

  // Counts cycles from the start edge to the done pulse, bounded.
  task automatic run_sweep(input int which, input int exp_n, input int exp_ones, input string tag);
    int n;
    logic d;
    logic [6:0] oc;
    @(negedge clk);
    case (which) 1: start1 = 1; 3: start3 = 1; default: start6 = 1; endcase
    @(negedge clk);
    start1 = 0; start3 = 0; start6 = 0;
    n = 1;
    forever begin
      case (which) 1: d = done1; 3: d = done3; default: d = done6; endcase
      if (d || n >= 200) break;
      @(negedge clk);
      n++;
    end
    case (which) 1: oc = 7'(ones1); 3: oc = 7'(ones3); default: oc = ones6; endcase
    chk({tag, "_done_cyc"}, n, exp_n);
    chk({tag, "_ones"}, oc, exp_ones);
  endtask

  initial begin
    logic [7:0] ld;
    #2;
    chk("rst_out", out3, 0);
    chk("rst_busy", busy3, 0);
    chk("rst_done", done3, 0);
    chk("rst_idx", sweep_idx3, 0);
    chk("rst_sout", sweep_out3, 0);
    chk("rst_ones", ones3, 0);
    chk("rst_rdy", cfg_ready3, 1);
    @(negedge clk); @(negedge clk);
    rst = 0;

    // Load majority: 1,1,1,0,1,0,0,0 -> tt = 8'hE8
    ld = 8'hE8;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      cfg_valid3 = 1; cfg_bit3 = ld[i];
    end
    @(negedge clk);
    cfg_valid3 = 0;
    in_vec3 = 3'b011;
    @(negedge clk);
    chk("eval_011", out3, 1);
    in_vec3 = 3'b100;
    @(negedge clk);
    chk("eval_100", out3, 0);
    in_vec3 = 3'b111;
    @(negedge clk);
    chk("eval_111", out3, 1);
    in_vec3 = 3'b000;
    @(negedge clk);
    chk("eval_000", out3, 0);

    sweep3(0, 0);
    sweep3(1, 0);
    sweep3(0, 1);

    // Reset mid-sweep at idx 5 with out driven high beforehand.
    in_vec3 = 3'b011;
    @(negedge clk);
    start3 = 1;
    @(negedge clk);
    start3 = 0;
    repeat (5) @(negedge clk);
    chk("pre_rst_idx", sweep_idx3, 5);
    chk("pre_rst_out", out3, 1);
    rst = 1;
    #1;
    chk("mid_rst_busy", busy3, 0);
    chk("mid_rst_ones", ones3, 0);
    chk("mid_rst_out", out3, 0);
    chk("mid_rst_idx", sweep_idx3, 0);
    chk("mid_rst_rdy", cfg_ready3, 1);
    @(negedge clk);
    rst = 0;
    in_vec3 = 3'b111;
    @(negedge clk);
    chk("tt_cleared", out3, 0);
    run_sweep(3, 9, 0, "n3_zero");

    // N_IN=1: load 1,0 -> tt = 2'b10
    @(negedge clk); cfg_valid1 = 1; cfg_bit1 = 1;
    @(negedge clk); cfg_bit1 = 0;
    @(negedge clk); cfg_valid1 = 0; in_vec1 = 1'b1;
    @(negedge clk);
    chk("n1_eval1", out1, 1);
    in_vec1 = 1'b0;
    @(negedge clk);
    chk("n1_eval0", out1, 0);
    run_sweep(1, 3, 1, "n1");

    // N_IN=6: all-ones table
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      cfg_valid6 = 1; cfg_bit6 = 1;
    end
    @(negedge clk);
    cfg_valid6 = 0; in_vec6 = 6'd37;
    @(negedge clk);
    chk("n6_eval", out6, 1);
    run_sweep(6, 65, 64, "n6");
    @(negedge clk);
    chk("n6_hold", ones6, 64);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
